// File: rtl/chacha_pkg.sv
// Shared types and helpers for the ChaCha column datapath: FSM states,
// rotate amounts, byte-bus address fields and byte insert/extract helpers.
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QR,
        ST_DIAG,
        ST_UNDIAG,
        ST_FF,
        ST_DONE
    } state_t;

    localparam int ROT16 = 16;
    localparam int ROT12 = 12;
    localparam int ROT8  = 8;
    localparam int ROT7  = 7;

    localparam int ROW_HI  = 5;
    localparam int ROW_LO  = 4;
    localparam int COL_HI  = 3;
    localparam int COL_LO  = 2;
    localparam int BYTE_HI = 1;
    localparam int BYTE_LO = 0;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  value);
        logic [31:0] result;
        result = word;
        result[{sel, 3'b000} +: 8] = value;
        return result;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word,
                                            input logic [1:0]  sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/chacha_arx_step.sv
// Combinational ARX step: one quarter of a ChaCha quarter-round, selected by step.
module chacha_arx_step
    import chacha_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [1:0]  step,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next
);

    logic [31:0] sum_ab;
    logic [31:0] sum_cd;

    always_comb begin
        sum_ab = a + b;
        sum_cd = c + d;
        a_next = a;
        b_next = b;
        c_next = c;
        d_next = d;
        case (step)
            2'd0: begin
                a_next = sum_ab;
                d_next = rotl32(d ^ sum_ab, ROT16);
            end
            2'd1: begin
                c_next = sum_cd;
                b_next = rotl32(b ^ sum_cd, ROT12);
            end
            2'd2: begin
                a_next = sum_ab;
                d_next = rotl32(d ^ sum_ab, ROT8);
            end
            default: begin
                c_next = sum_cd;
                b_next = rotl32(b ^ sum_cd, ROT7);
            end
        endcase
    end

endmodule

// File: rtl/qr_column.sv
// One ChaCha state column with byte-bus load/readback and an ARX sequencer.
// Optional FEEDFORWARD_EN adds the start-time state back after the last round.
module qr_column
    import chacha_pkg::*;
#(
    parameter logic [1:0]  COL    = 2'd0,
    parameter logic [31:0] A_INIT = 32'h0,
    parameter int          ROUNDS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        write,
    input  logic [5:0]  addr_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] b_word,
    output logic [31:0] c_word,
    output logic [31:0] d_word,
    input  logic [31:0] b_fwd_in,
    input  logic [31:0] b_bwd_in,
    input  logic [31:0] c_swap_in,
    input  logic [31:0] d_fwd_in,
    input  logic [31:0] d_bwd_in
);

    localparam int            RW         = 5;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
`ifdef FEEDFORWARD_EN
    localparam state_t        FIN_STATE  = ST_FF;
`else
    localparam state_t        FIN_STATE  = ST_DONE;
`endif

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] round;
    logic [1:0]    step;
    logic [31:0]   a_reg, b_reg, c_reg, d_reg;
    logic [31:0]   a_arx, b_arx, c_arx, d_arx;
    logic [31:0]   row_word;
    logic          idle_or_done, sel_col, start_ok, write_ok;
    logic          round_odd, last_round;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign sel_col      = (addr_in[COL_HI:COL_LO] == COL);
    assign start_ok     = start && !hold && idle_or_done;
    // A simultaneous start takes priority, so the write is dropped.
    assign write_ok     = write && !hold && idle_or_done && sel_col && !start_ok;
    assign round_odd    = round[0];
    assign last_round   = (round == LAST_ROUND);

    assign busy   = (state == ST_QR) || (state == ST_DIAG) ||
                    (state == ST_UNDIAG) || (state == ST_FF);
    assign done   = (state == ST_DONE);
    assign b_word = b_reg;
    assign c_word = c_reg;
    assign d_word = d_reg;

    chacha_arx_step u_arx (
        .a      (a_reg),
        .b      (b_reg),
        .c      (c_reg),
        .d      (d_reg),
        .step   (step),
        .a_next (a_arx),
        .b_next (b_arx),
        .c_next (c_arx),
        .d_next (d_arx)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_QR;
            ST_QR: begin
                if (step == 2'd3) begin
                    if (round_odd)       state_next = ST_UNDIAG;
                    else if (last_round) state_next = FIN_STATE;
                    else                 state_next = ST_DIAG;
                end
            end
            ST_DIAG:   state_next = ST_QR;
            ST_UNDIAG: state_next = last_round ? FIN_STATE : ST_QR;
            ST_FF:     state_next = ST_DONE;
            ST_DONE: begin
                if (start_ok)      state_next = ST_QR;
                else if (write_ok) state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            round <= '0;
            step  <= '0;
        end else if (!hold) begin
            state <= state_next;
            if (start_ok) begin
                round <= '0;
                step  <= '0;
            end else if (state == ST_QR) begin
                step <= step + 2'd1;
                if (step == 2'd3 && !round_odd) round <= round + RW'(1);
            end else if (state == ST_UNDIAG) begin
                round <= round + RW'(1);
            end
        end
    end

`ifdef FEEDFORWARD_EN
    logic [31:0] a_shadow, b_shadow, c_shadow, d_shadow;

    always_ff @(posedge clk) begin
        if (start_ok) begin
            a_shadow <= a_reg;
            b_shadow <= b_reg;
            c_shadow <= c_reg;
            d_shadow <= d_reg;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= A_INIT;
            b_reg <= '0;
            c_reg <= '0;
            d_reg <= '0;
        end else if (!hold) begin
            case (state)
                ST_QR: begin
                    a_reg <= a_arx;
                    b_reg <= b_arx;
                    c_reg <= c_arx;
                    d_reg <= d_arx;
                end
                // Diagonal rounds rotate rows b/c/d across the four columns.
                ST_DIAG: begin
                    b_reg <= b_fwd_in;
                    c_reg <= c_swap_in;
                    d_reg <= d_fwd_in;
                end
                ST_UNDIAG: begin
                    b_reg <= b_bwd_in;
                    c_reg <= c_swap_in;
                    d_reg <= d_bwd_in;
                end
`ifdef FEEDFORWARD_EN
                ST_FF: begin
                    a_reg <= a_reg + a_shadow;
                    b_reg <= b_reg + b_shadow;
                    c_reg <= c_reg + c_shadow;
                    d_reg <= d_reg + d_shadow;
                end
`endif
                default: begin
                    if (write_ok) begin
                        case (addr_in[ROW_HI:ROW_LO])
                            2'd0:    a_reg <= put_byte(a_reg, addr_in[BYTE_HI:BYTE_LO], data_in);
                            2'd1:    b_reg <= put_byte(b_reg, addr_in[BYTE_HI:BYTE_LO], data_in);
                            2'd2:    c_reg <= put_byte(c_reg, addr_in[BYTE_HI:BYTE_LO], data_in);
                            default: d_reg <= put_byte(d_reg, addr_in[BYTE_HI:BYTE_LO], data_in);
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        row_word = a_reg;
        case (addr_in[ROW_HI:ROW_LO])
            2'd1:    row_word = b_reg;
            2'd2:    row_word = c_reg;
            2'd3:    row_word = d_reg;
            default: row_word = a_reg;
        endcase
        data_out = sel_col ? get_byte(row_word, addr_in[BYTE_HI:BYTE_LO]) : 8'h00;
    end

endmodule

// File: tb/tb_qr_column.sv
// Scoreboard bench for qr_column: a single ROUNDS=1 column plus a four-column ROUNDS=20 block.
// Expectations track FEEDFORWARD_EN when the bench is built with it.
module tb_qr_column;

`ifdef FEEDFORWARD_EN
    localparam logic [31:0] QA = 32'hfb3ba405, QB = 32'hcc1efbd2, QC = 32'he10eb671, QD = 32'h59a50a22;
    localparam int S_LAT = 5, K_LAT = 101;
    localparam logic [31:0] KA0 = 32'he4e7f110, KA1 = 32'h15593bd1, KB0 = 32'hc7f4d1c7,
                            KB1 = 32'h0368c033, KC0 = 32'h466482d2;
`else
    localparam logic [31:0] QA = 32'hea2a92f4, QB = 32'hcb1cf8ce, QC = 32'h4581472e, QD = 32'h5881c4bb;
    localparam int S_LAT = 4, K_LAT = 100;
    localparam logic [31:0] KA0 = 32'h837778ab, KA1 = 32'he238d763, KB0 = 32'hc4f2d0c7,
                            KB1 = 32'hfc62bb2f, KC0 = 32'h335271c2;
`endif
    localparam logic [31:0] A_CONST [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
    localparam logic [31:0] D_INIT  [4] = '{32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

    localparam int S_A = 0, S_B = 1, S_C = 2, S_D = 3, S_BUSY = 4, S_DONE = 5, S_DOUT = 6, S_LEN = 7,
                   K_A0 = 8, K_A1 = 9, K_A2 = 10, K_A3 = 11, K_B0 = 12, K_B1 = 13, K_C0 = 14,
                   K_BCD = 15, K_BUSY = 16, K_DONE = 17, K_LEN = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst_n, s_hold, s_write, s_start, s_busy, s_done;
    logic [5:0]  s_addr;
    logic [7:0]  s_din, s_dout;
    logic [31:0] s_b, s_c, s_d;

    logic        k_rst_n, k_hold, k_write, k_start;
    logic [5:0]  k_addr;
    logic [7:0]  k_din;
    logic [7:0]  k_dout [4];
    logic [3:0]  k_busy, k_done;
    logic [31:0] kb [4];
    logic [31:0] kc [4];
    logic [31:0] kd [4];

    qr_column #(.COL(2'd0), .A_INIT(32'h0), .ROUNDS(1)) u_s (
        .clk(clk), .rst_n(s_rst_n), .hold(s_hold), .write(s_write), .addr_in(s_addr),
        .data_in(s_din), .data_out(s_dout), .start(s_start), .busy(s_busy), .done(s_done),
        .b_word(s_b), .c_word(s_c), .d_word(s_d),
        .b_fwd_in(32'h0), .b_bwd_in(32'h0), .c_swap_in(32'h0), .d_fwd_in(32'h0), .d_bwd_in(32'h0)
    );

    for (genvar i = 0; i < 4; i++) begin : g_col
        qr_column #(.COL(2'(i)), .A_INIT(A_CONST[i]), .ROUNDS(20)) u_col (
            .clk(clk), .rst_n(k_rst_n), .hold(k_hold), .write(k_write), .addr_in(k_addr),
            .data_in(k_din), .data_out(k_dout[i]), .start(k_start), .busy(k_busy[i]),
            .done(k_done[i]), .b_word(kb[i]), .c_word(kc[i]), .d_word(kd[i]),
            .b_fwd_in(kb[(i+1)%4]), .b_bwd_in(kb[(i+3)%4]), .c_swap_in(kc[(i+2)%4]),
            .d_fwd_in(kd[(i+3)%4]), .d_bwd_in(kd[(i+1)%4])
        );
    end

    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    logic  probe_req = 1'b0;

    // Busy-to-done latency, measured independently for each group.
    int   cyc = 0;
    int   s_rise = 0, s_fin = 0, k_rise = 0, k_fin = 0;
    logic s_busy_q = 1'b0, s_done_q = 1'b0, k_busy_q = 1'b0, k_done_q = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (s_busy && !s_busy_q) s_rise = cyc;
        if (s_done && !s_done_q) s_fin  = cyc;
        if (k_busy[0] && !k_busy_q) k_rise = cyc;
        if (k_done[0] && !k_done_q) k_fin  = cyc;
        s_busy_q = s_busy;
        s_done_q = s_done;
        k_busy_q = k_busy[0];
        k_done_q = k_done[0];
    end

    function automatic logic [31:0] sample(input int src);
        case (src)
            S_A:     return u_s.a_reg;
            S_B:     return s_b;
            S_C:     return s_c;
            S_D:     return s_d;
            S_BUSY:  return {31'd0, s_busy};
            S_DONE:  return {31'd0, s_done};
            S_DOUT:  return {24'd0, s_dout};
            S_LEN:   return 32'(s_fin - s_rise);
            K_A0:    return g_col[0].u_col.a_reg;
            K_A1:    return g_col[1].u_col.a_reg;
            K_A2:    return g_col[2].u_col.a_reg;
            K_A3:    return g_col[3].u_col.a_reg;
            K_B0:    return kb[0];
            K_B1:    return kb[1];
            K_C0:    return kc[0];
            K_BCD:   return kb[0] | kb[1] | kb[2] | kb[3] | kc[0] | kc[1] | kc[2] | kc[3] |
                            kd[0] | kd[1] | kd[2] | kd[3];
            K_BUSY:  return {28'd0, k_busy};
            K_DONE:  return {28'd0, k_done};
            K_LEN:   return 32'(k_fin - k_rise);
            default: return 32'hdeadbeef;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        item_t       it;
        logic [31:0] act;
        if (probe_req) begin
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = sample(it.src);
                n_vec++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int src, input logic [31:0] exp);
        item_t it;
        it.name = name;
        it.src  = src;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic probe();
        probe_req = 1'b1;
        @(negedge clk);
        #1 probe_req = 1'b0;
    endtask

    task automatic s_wr(input logic [5:0] a, input logic [7:0] v);
        @(negedge clk);
        s_addr = a; s_din = v; s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic s_wr_word(input logic [1:0] row, input logic [31:0] w);
        for (int bi = 0; bi < 4; bi++) s_wr({row, 2'd0, 2'(bi)}, w[bi*8 +: 8]);
    endtask

    task automatic s_load();
        s_wr_word(2'd0, 32'h11111111);
        s_wr_word(2'd1, 32'h01020304);
        s_wr_word(2'd2, 32'h9b8d6f43);
        s_wr_word(2'd3, 32'h01234567);
    endtask

    task automatic s_go();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic k_wr_word(input logic [1:0] row, input logic [1:0] col, input logic [31:0] w);
        for (int bi = 0; bi < 4; bi++) begin
            @(negedge clk);
            k_addr = {row, col, 2'(bi)}; k_din = w[bi*8 +: 8]; k_write = 1'b1;
            @(negedge clk);
            k_write = 1'b0;
        end
    endtask

    task automatic wait_done(input bit blk, input int max_cyc);
        int n = 0;
        while (!(blk ? k_done[0] : s_done) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_vec++;
        if ((blk ? k_done[0] : s_done) !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_done: done not seen within %0d cycles", max_cyc);
        end
    endtask

    task automatic expect_qr(input string tag);
        expect_val({tag, "_done"}, S_DONE, 32'd1);
        expect_val({tag, "_a"}, S_A, QA);
        expect_val({tag, "_b"}, S_B, QB);
        expect_val({tag, "_c"}, S_C, QC);
        expect_val({tag, "_d"}, S_D, QD);
    endtask

    initial begin
        s_rst_n = 1'b0; s_hold = 1'b0; s_write = 1'b0; s_start = 1'b0; s_addr = '0; s_din = '0;
        k_rst_n = 1'b0; k_hold = 1'b0; k_write = 1'b0; k_start = 1'b0; k_addr = '0; k_din = '0;
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1; k_rst_n = 1'b1;

        // Reset state
        #1;
        n_vec++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || u_s.a_reg !== 32'h0 || s_b !== 32'h0 ||
            s_c !== 32'h0 || s_d !== 32'h0 || k_busy !== 4'h0 || k_done !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b a=%h b=%h c=%h d=%h kbusy=%h kdone=%h",
                     s_busy, s_done, u_s.a_reg, s_b, s_c, s_d, k_busy, k_done);
        end
        expect_val("rst_a", S_A, 32'h0);
        expect_val("rst_b", S_B, 32'h0);
        expect_val("rst_c", S_C, 32'h0);
        expect_val("rst_d", S_D, 32'h0);
        expect_val("rst_busy", S_BUSY, 32'h0);
        expect_val("rst_done", S_DONE, 32'h0);
        expect_val("rst_blk_a0", K_A0, A_CONST[0]);
        expect_val("rst_blk_busy", K_BUSY, 32'h0);
        probe();

        // Single quarter-round (RFC 7539 2.1.1)
        s_load();
        s_go();
        wait_done(1'b0, 50);
        expect_qr("qr");
        expect_val("qr_latency", S_LEN, 32'(S_LAT));
        probe();

        // Hold for 7 cycles mid-QR
        s_load();
        s_go();
        @(negedge clk);
        s_hold = 1'b1;
        repeat (7) @(negedge clk);
        s_hold = 1'b0;
        wait_done(1'b0, 50);
        expect_qr("hold");
        expect_val("hold_latency", S_LEN, 32'(S_LAT + 7));
        probe();

        // Write while busy is ignored
        s_load();
        s_go();
        s_wr({2'd1, 2'd0, 2'd0}, 8'hff);
        wait_done(1'b0, 50);
        expect_qr("busywr");
        probe();

        // start and write together: write dropped, start from current contents
        @(negedge clk);
        s_start = 1'b1; s_write = 1'b1; s_addr = {2'd0, 2'd0, 2'd0}; s_din = 8'h55;
        @(posedge clk);
        #1 s_start = 1'b0; s_write = 1'b0;
        expect_val("stwr_a", S_A, QA);
        expect_val("stwr_busy", S_BUSY, 32'd1);
        probe();
        wait_done(1'b0, 50);
        expect_val("stwr_done", S_DONE, 32'd1);
        probe();

        // Write in DONE returns to IDLE; byte-lane and column decode
        s_wr_word(2'd2, 32'h9b8d6f43);
        expect_val("wrdone_done", S_DONE, 32'd0);
        expect_val("wrdone_busy", S_BUSY, 32'd0);
        expect_val("wrdone_c", S_C, 32'h9b8d6f43);
        probe();
        s_wr({2'd2, 2'd0, 2'd2}, 8'haa);
        expect_val("byte2_c", S_C, 32'h9baa6f43);
        probe();
        @(negedge clk);
        s_addr = {2'd2, 2'd1, 2'd2};
        expect_val("dout_other_col", S_DOUT, 32'h0);
        probe();
        @(negedge clk);
        s_addr = {2'd2, 2'd0, 2'd2};
        expect_val("dout_own_col", S_DOUT, 32'haa);
        probe();

        // Full ChaCha20 block (RFC 7539 2.3.2)
        for (int ci = 0; ci < 4; ci++) begin
            k_wr_word(2'd1, 2'(ci), 32'h03020100 + 32'h04040404 * ci);
            k_wr_word(2'd2, 2'(ci), 32'h13121110 + 32'h04040404 * ci);
            k_wr_word(2'd3, 2'(ci), D_INIT[ci]);
        end
        @(negedge clk);
        k_start = 1'b1;
        @(negedge clk);
        k_start = 1'b0;
        wait_done(1'b1, 400);
        expect_val("blk_done", K_DONE, 32'hf);
        expect_val("blk_latency", K_LEN, 32'(K_LAT));
        expect_val("blk_a0", K_A0, KA0);
        expect_val("blk_a1", K_A1, KA1);
        expect_val("blk_b0", K_B0, KB0);
        expect_val("blk_b1", K_B1, KB1);
        expect_val("blk_c0", K_C0, KC0);
        probe();

        // Async reset mid-computation
        @(negedge clk);
        k_start = 1'b1;
        @(negedge clk);
        k_start = 1'b0;
        repeat (20) @(negedge clk);
        expect_val("mid_busy", K_BUSY, 32'hf);
        probe();
        repeat (28) @(posedge clk);
        #1 k_rst_n = 1'b0;
        expect_val("arst_a0", K_A0, A_CONST[0]);
        expect_val("arst_a1", K_A1, A_CONST[1]);
        expect_val("arst_a2", K_A2, A_CONST[2]);
        expect_val("arst_a3", K_A3, A_CONST[3]);
        expect_val("arst_bcd", K_BCD, 32'h0);
        expect_val("arst_busy", K_BUSY, 32'h0);
        expect_val("arst_done", K_DONE, 32'h0);
        probe();
        k_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else            $display("PASS");
        $finish;
    end

endmodule
